// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch sequencer: FSM states, branch condition
// codes, program-counter type and the branch-condition evaluator.
package fetch_unit_pkg;

    localparam int DEF_PC_W       = 10;
    localparam int DEF_LUT_DEPTH  = 4;
    localparam int DEF_START_ADDR = 0;

    typedef logic [DEF_PC_W-1:0] pc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        C_ALWAYS = 2'd0,
        C_EQ     = 2'd1,
        C_NE     = 2'd2,
        C_NEG    = 2'd3
    } cond_t;

    // True when the condition code is satisfied by the current ALU flags.
    function automatic logic cond_met(input cond_t c, input logic zero, input logic neg);
        logic r;
        r = 1'b0;
        case (c)
            C_ALWAYS: r = 1'b1;
            C_EQ:     r = zero;
            C_NE:     r = ~zero;
            C_NEG:    r = neg;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// Branch-target register file: DEPTH x W entries, one combinational read
// port, one synchronous write port, asynchronous clear to zero.
// A read of the entry being written returns the old value; the new value
// lands on the clock edge.
module fetch_unit_branch_lut #(
    parameter int W     = 10,
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [W-1:0]     wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [W-1:0]     rd_data
);

    logic [W-1:0] mem [DEPTH];

    // Table storage: cleared on reset, written on the edge when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/fetch_unit.sv
// Program-counter / fetch sequencer.
// States IDLE -> RUN -> HALT; Start from IDLE or HALT (re)starts at
// START_ADDR. In RUN the PC advances by one per cycle unless stalled,
// halted by Ack, or redirected by a taken branch through the target table.
// Optional macro FETCH_BRANCH_COUNT_EN adds a saturating taken-branch
// counter on BranchCount; without it BranchCount is constant zero.
//
// Handshake: Start is a single-cycle request sampled on the rising edge,
// honoured only in IDLE or HALT; Done is high for as long as the unit sits
// in HALT and drops on the same edge that accepts the next Start.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_W       = DEF_PC_W,
    parameter int LUT_DEPTH  = DEF_LUT_DEPTH,
    parameter int START_ADDR = DEF_START_ADDR
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Stall,
    input  logic            ConditionalJump,
    input  logic            BranchAbsOrRel,
    input  logic [1:0]      BranchConditions,
    input  logic [1:0]      TargIdx,
    input  logic            Ack,
    input  logic            ZeroFlag,
    input  logic            NegFlag,
    input  logic            LutWrEn,
    input  logic [1:0]      LutWrIdx,
    input  logic [PC_W-1:0] LutWrData,
    output logic [PC_W-1:0] ProgCtr,
    output logic            Running,
    output logic            Done,
    output logic [15:0]     BranchCount,
    output fetch_state_t    state_dbg
);

    fetch_state_t    state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] lut_rd;
    logic [PC_W-1:0] pc_branch;
    logic            lut_we;
    logic            cond_ok;
    logic            branch_taken;
    logic            start_accept;
    logic            run_active;

    // The table is frozen while a program runs.
    assign lut_we = LutWrEn && (state_q != RUN);

    fetch_unit_branch_lut #(
        .W     (PC_W),
        .DEPTH (LUT_DEPTH),
        .IDX_W (2)
    ) u_lut (
        .clk     (Clk),
        .rst_n   (Reset),
        .wr_en   (lut_we),
        .wr_idx  (LutWrIdx),
        .wr_data (LutWrData),
        .rd_idx  (TargIdx),
        .rd_data (lut_rd)
    );

    assign cond_ok      = cond_met(cond_t'(BranchConditions), ZeroFlag, NegFlag);
    assign branch_taken = ConditionalJump && cond_ok;
    // Relative targets add modulo 2^PC_W, so negative offsets wrap naturally.
    assign pc_branch    = BranchAbsOrRel ? (pc_q + lut_rd) : lut_rd;
    assign start_accept = Start && (state_q != RUN);
    // A RUN cycle that can move the PC or take a branch: not stalled, no halt.
    assign run_active   = (state_q == RUN) && !Stall && !Ack;

    // FSM and program counter; priority in RUN is Stall > Ack > branch > +1.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            case (state_q)
                IDLE, HALT: begin
                    if (Start) begin
                        state_q <= RUN;
                        pc_q    <= PC_W'(START_ADDR);
                    end
                end
                RUN: begin
                    if (Stall) begin
                        state_q <= RUN;
                    end else if (Ack) begin
                        state_q <= HALT;
                    end else if (branch_taken) begin
                        pc_q <= pc_branch;
                    end else begin
                        pc_q <= pc_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    pc_q    <= '0;
                end
            endcase
        end
    end

    assign ProgCtr   = pc_q;
    assign Running   = (state_q == RUN);
    assign Done      = (state_q == HALT);
    assign state_dbg = state_q;

`ifdef FETCH_BRANCH_COUNT_EN
    logic [15:0] bcount_q;

    // Saturating count of taken branches; restarts from zero on each Start.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            bcount_q <= '0;
        end else if (start_accept) begin
            bcount_q <= '0;
        end else if (run_active && branch_taken && (bcount_q != 16'hFFFF)) begin
            bcount_q <= bcount_q + 16'd1;
        end
    end

    assign BranchCount = bcount_q;
`else
    logic unused_cnt;

    // Counter disabled: these terms only feed the optional counter.
    assign unused_cnt  = start_accept ^ run_active;
    assign BranchCount = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequencing, absolute/relative branches,
// condition codes, wrap-around, Ack/Stall priority, HALT restart, table
// write gating and asynchronous reset mid-program.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic         Stall;
    logic         ConditionalJump;
    logic         BranchAbsOrRel;
    logic [1:0]   BranchConditions;
    logic [1:0]   TargIdx;
    logic         Ack;
    logic         ZeroFlag;
    logic         NegFlag;
    logic         LutWrEn;
    logic [1:0]   LutWrIdx;
    logic [9:0]   LutWrData;
    logic [9:0]   ProgCtr;
    logic         Running;
    logic         Done;
    logic [15:0]  BranchCount;
    fetch_state_t state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .Start            (Start),
        .Stall            (Stall),
        .ConditionalJump  (ConditionalJump),
        .BranchAbsOrRel   (BranchAbsOrRel),
        .BranchConditions (BranchConditions),
        .TargIdx          (TargIdx),
        .Ack              (Ack),
        .ZeroFlag         (ZeroFlag),
        .NegFlag          (NegFlag),
        .LutWrEn          (LutWrEn),
        .LutWrIdx         (LutWrIdx),
        .LutWrData        (LutWrData),
        .ProgCtr          (ProgCtr),
        .Running          (Running),
        .Done             (Done),
        .BranchCount      (BranchCount),
        .state_dbg        (state_dbg)
    );

    // Clock
    always #5 Clk = ~Clk;

    // Expected branch count: the counter exists only when the macro is set.
    function automatic logic [31:0] exp_cnt(input int n);
`ifdef FETCH_BRANCH_COUNT_EN
        return 32'(n);
`else
        return 32'(n - n);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Advance one clock; outputs are stable 1 time unit after the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        Start            = 1'b0;
        Stall            = 1'b0;
        ConditionalJump  = 1'b0;
        BranchAbsOrRel   = 1'b0;
        BranchConditions = 2'b00;
        TargIdx          = 2'b00;
        Ack              = 1'b0;
        ZeroFlag         = 1'b0;
        NegFlag          = 1'b0;
        LutWrEn          = 1'b0;
        LutWrIdx         = 2'b00;
        LutWrData        = 10'd0;
    endtask

    task automatic lut_write(input logic [1:0] idx, input logic [9:0] data);
        LutWrEn   = 1'b1;
        LutWrIdx  = idx;
        LutWrData = data;
        tick();
        LutWrEn   = 1'b0;
    endtask

    // Present one branch instruction for a single cycle, then check the PC.
    task automatic br(input string tag, input logic rel, input logic [1:0] cond,
                      input logic [1:0] idx, input logic z, input logic n,
                      input logic [9:0] exp_pc);
        ConditionalJump  = 1'b1;
        BranchAbsOrRel   = rel;
        BranchConditions = cond;
        TargIdx          = idx;
        ZeroFlag         = z;
        NegFlag          = n;
        tick();
        clear_inputs();
        check(tag, 32'(ProgCtr), 32'(exp_pc));
    endtask

    initial begin
        clear_inputs();
        Reset = 1'b0;
        tick();
        tick();
        check("rst_pc", 32'(ProgCtr), 32'd0);
        check("rst_running", 32'(Running), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_count", 32'(BranchCount), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        Reset = 1'b1;
        tick();

        // Load the table while idle.
        lut_write(2'd2, 10'd100);
        lut_write(2'd1, 10'h3FE);
        lut_write(2'd0, 10'd5);
        lut_write(2'd3, 10'd1022);
        check("idle_pc_hold", 32'(ProgCtr), 32'd0);
        check("idle_state", 32'(state_dbg), 32'(IDLE));

        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("start_pc", 32'(ProgCtr), 32'd0);
        check("start_running", 32'(Running), 32'd1);
        check("start_done", 32'(Done), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("seq_pc", 32'(ProgCtr), 32'(i));
        end

        br("abs_always", 1'b0, 2'b00, 2'd2, 1'b0, 1'b0, 10'd100);
        br("eq_not_taken", 1'b0, 2'b01, 2'd2, 1'b0, 1'b0, 10'd101);
        br("ne_rel_back2", 1'b1, 2'b10, 2'd1, 1'b0, 1'b0, 10'd99);
        br("neg_not_taken", 1'b0, 2'b11, 2'd0, 1'b0, 1'b0, 10'd100);
        br("neg_taken", 1'b0, 2'b11, 2'd0, 1'b0, 1'b1, 10'd5);
        check("count_3", 32'(BranchCount), exp_cnt(3));
        tick();
        check("seq_6", 32'(ProgCtr), 32'd6);
        tick();
        check("seq_7", 32'(ProgCtr), 32'd7);
        br("rel_at_7", 1'b1, 2'b00, 2'd1, 1'b0, 1'b0, 10'd5);
        br("eq_taken", 1'b0, 2'b01, 2'd2, 1'b1, 1'b0, 10'd100);
        br("abs_to_1022", 1'b0, 2'b00, 2'd3, 1'b0, 1'b0, 10'd1022);
        br("rel_wrap", 1'b1, 2'b00, 2'd0, 1'b0, 1'b0, 10'd3);
        br("abs_to_1022b", 1'b0, 2'b00, 2'd3, 1'b0, 1'b0, 10'd1022);
        tick();
        check("seq_1023", 32'(ProgCtr), 32'd1023);
        tick();
        check("wrap_0", 32'(ProgCtr), 32'd0);

        // Table write and Start are both ignored while running.
        LutWrEn   = 1'b1;
        LutWrIdx  = 2'd2;
        LutWrData = 10'd555;
        Start     = 1'b1;
        tick();
        clear_inputs();
        check("start_in_run_pc", 32'(ProgCtr), 32'd1);
        check("start_in_run_state", 32'(state_dbg), 32'(RUN));
        for (int i = 2; i <= 9; i++) begin
            tick();
        end
        check("seq_9", 32'(ProgCtr), 32'd9);

        // Ack beats a simultaneous taken branch.
        Ack              = 1'b1;
        ConditionalJump  = 1'b1;
        BranchConditions = 2'b00;
        TargIdx          = 2'd2;
        tick();
        clear_inputs();
        check("halt_pc", 32'(ProgCtr), 32'd9);
        check("halt_done", 32'(Done), 32'd1);
        check("halt_running", 32'(Running), 32'd0);
        check("halt_state", 32'(state_dbg), 32'(HALT));
        check("count_8", 32'(BranchCount), exp_cnt(8));
        tick();
        check("halt_hold_pc", 32'(ProgCtr), 32'd9);
        check("halt_hold_done", 32'(Done), 32'd1);

        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("restart_pc", 32'(ProgCtr), 32'd0);
        check("restart_done", 32'(Done), 32'd0);
        check("restart_running", 32'(Running), 32'd1);
        check("restart_count", 32'(BranchCount), exp_cnt(0));

        // Stall dominates both Ack and a taken branch.
        Stall            = 1'b1;
        Ack              = 1'b1;
        ConditionalJump  = 1'b1;
        BranchConditions = 2'b00;
        TargIdx          = 2'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", 32'(ProgCtr), 32'd0);
            check("stall_state", 32'(state_dbg), 32'(RUN));
        end
        Stall = 1'b0;
        Ack   = 1'b0;
        tick();
        clear_inputs();
        check("unstall_branch", 32'(ProgCtr), 32'd100);
        check("unstall_count", 32'(BranchCount), exp_cnt(1));
        tick();
        check("seq_101", 32'(ProgCtr), 32'd101);

        // Asynchronous reset mid-program takes effect without a clock edge.
        Reset = 1'b0;
        #1;
        check("async_rst_pc", 32'(ProgCtr), 32'd0);
        check("async_rst_state", 32'(state_dbg), 32'(IDLE));
        check("async_rst_running", 32'(Running), 32'd0);
        check("async_rst_count", 32'(BranchCount), 32'd0);
        tick();
        Reset = 1'b1;
        tick();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        br("lut2_cleared", 1'b0, 2'b00, 2'd2, 1'b0, 1'b0, 10'd0);
        br("lut3_cleared", 1'b0, 2'b00, 2'd3, 1'b0, 1'b0, 10'd0);
        tick();
        check("post_rst_seq", 32'(ProgCtr), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
